// File: rtl/psp_arb_pkg.sv
// Shared types and constants for the PSP memory arbiter.
package psp_arb_pkg;

    localparam int unsigned MAX_PORTS   = 8;
    localparam int unsigned MAX_LATENCY = 4;

    // Port-id width: clog2(n), never narrower than one bit.
    function automatic int unsigned port_id_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned MAX_ID_W = port_id_w(MAX_PORTS);

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] port;
        logic                we;
    } inflight_t;

endpackage

// File: rtl/psp_rr_arbiter.sv
// Single-grant arbiter: round-robin by default, lowest-index-wins when
// PSP_ARB_FIXED_PRIORITY_EN is defined (rr_ptr then does not exist).
module psp_rr_arbiter
    import psp_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            valid,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [port_id_w(NUM_PORTS)-1:0] grant_id,
    output logic                            grant_any
);
    localparam int unsigned PW = port_id_w(NUM_PORTS);

    assign grant = grant_any ? (NUM_PORTS'(1) << grant_id) : '0;

`ifdef PSP_ARB_FIXED_PRIORITY_EN
    logic unused_ok;
    assign unused_ok = clk ^ reset;

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!grant_any && valid[i]) begin
                grant_any = 1'b1;
                grant_id  = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr;

    // (base + off) mod NUM_PORTS, with off < NUM_PORTS
    function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base,
                                              input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_PORTS) s = s - NUM_PORTS;
        return PW'(s);
    endfunction

    // Search starts at rr_ptr and wraps past the last port.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!grant_any && valid[rot_idx(rr_ptr, i)]) begin
                grant_any = 1'b1;
                grant_id  = rot_idx(rr_ptr, i);
            end
        end
    end

    // With one port the wrap keeps the pointer at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= rot_idx(grant_id, 1);
        end
    end
`endif

endmodule

// File: rtl/psp_mem_arbiter.sv
// N-port arbiter onto a single memory with a fixed read latency.
// Optional build macro: PSP_ARB_FIXED_PRIORITY_EN (fixed priority instead of round-robin).
module psp_mem_arbiter
    import psp_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    output logic [NUM_PORTS-1:0]             req_ready,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS-1:0]             req_we,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic [DATA_W-1:0]                rsp_rdata,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_data_i,
    input  logic [DATA_W-1:0]                mem_data_o,
    output logic                             mem_data_en,
    output logic                             mem_write_en
);
    localparam int unsigned PW = port_id_w(NUM_PORTS);

    if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS ||
        MEM_LATENCY < 1 || MEM_LATENCY > MAX_LATENCY) begin : g_bad_param
        $error("psp_mem_arbiter: NUM_PORTS or MEM_LATENCY out of range");
    end

    logic [NUM_PORTS-1:0] live_valid;
    logic [PW-1:0]        grant_id;
    logic                 grant_any;
    inflight_t            pipe [MEM_LATENCY];
    inflight_t            tail;

    // Reset masks requests so no grant or memory strobe escapes while held.
    assign live_valid = reset ? '0 : req_valid;

    psp_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (live_valid),
        .grant     (req_ready),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    // Winner's request goes straight to memory in the grant cycle.
    always_comb begin
        mem_data_en  = grant_any;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_i   = '0;
        if (grant_any) begin
            mem_write_en = req_we[grant_id];
            mem_addr     = req_addr[grant_id];
            mem_data_i   = req_wdata[grant_id];
        end
    end

    // In-flight tracker, one stage per cycle of memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].valid <= grant_any;
            pipe[0].port  <= MAX_ID_W'(grant_id);
            pipe[0].we    <= mem_write_en;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail      = pipe[MEM_LATENCY-1];
    assign rsp_valid = tail.valid ? (NUM_PORTS'(1) << tail.port) : '0;
    assign rsp_rdata = (tail.valid && !tail.we) ? mem_data_o : '0;

endmodule
